// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//   Shared types and default parameters for the debounce / edge-detect block.
//   db_state_t        : debouncer FSM state encoding
//   SYNC_STAGES_DEF   : default synchroniser depth
//   DB_CYCLES_DEF     : default debounce persistence, in enabled cycles
//   CNT_W_DEF         : default transition counter width
// ---------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        TO_HIGH = 2'd1,
        HIGH    = 2'd2,
        TO_LOW  = 2'd3
    } db_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 4;
    localparam int CNT_W_DEF       = 8;

endpackage : debounce_pkg

// File: rtl/debounce_edge_det_bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
//   Multi-flop synchroniser for a single asynchronous bit.
//   Ports:
//     clk     : sampling clock
//     rst_n   : asynchronous active-low reset, clears the whole chain
//     d_async : raw asynchronous input
//     s       : synchronised output (last flop of the chain)
//   Parameter STAGES (>= 2) sets the chain depth.
// ---------------------------------------------------------------------------
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic s
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d_async};
        end
    end

    assign s = chain[STAGES-1];

endmodule : bit_sync

// File: rtl/debounce_edge_det.sv
// ---------------------------------------------------------------------------
// debounce_edge_det
//   Synchronises, debounces and edge-detects a raw asynchronous input so that
//   downstream logic only ever sees a clean, clock-aligned level.
//   Ports:
//     clk      : single clock, all state updates on posedge
//     rst_n    : asynchronous active-low reset
//     en       : debounce evaluation enable (sync chain runs regardless)
//     d_async  : raw asynchronous input
//     cnt_clr  : synchronous clear of edge_cnt, wins over an increment
//     q        : debounced, registered level
//     rise     : one-cycle pulse on an accepted 0->1
//     fall     : one-cycle pulse on an accepted 1->0
//     edge_cnt : saturating count of accepted transitions
//   Parameters: SYNC_STAGES (>= 2), DB_CYCLES (>= 1), CNT_W.
// ---------------------------------------------------------------------------
module debounce_edge_det
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d_async,
    input  logic             cnt_clr,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int               CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DB_CYCLES - 1);

    db_state_t     state;
    logic [CW-1:0] cnt;
    logic          s;
    logic          take_rise;
    logic          take_fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (d_async),
        .s       (s)
    );

    // Acceptance is decided combinationally so the edge counter can move on
    // the same clock edge that q, rise and fall update.
    always_comb begin
        take_rise = 1'b0;
        take_fall = 1'b0;
        if (en) begin
            if (s && (((state == LOW) && (DB_CYCLES == 1)) ||
                      ((state == TO_HIGH) && (cnt == CNT_LAST)))) begin
                take_rise = 1'b1;
            end
            if (!s && (((state == HIGH) && (DB_CYCLES == 1)) ||
                       ((state == TO_LOW) && (cnt == CNT_LAST)))) begin
                take_fall = 1'b1;
            end
        end
    end

    // Debounce FSM: pulses default to 0 every cycle, so they last exactly one
    // cycle and are also forced low whenever en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                unique case (state)
                    LOW: begin
                        if (take_rise) begin
                            state <= HIGH;
                            q     <= 1'b1;
                            rise  <= 1'b1;
                            cnt   <= '0;
                        end else if (s) begin
                            state <= TO_HIGH;
                            cnt   <= CW'(1);
                        end
                    end
                    TO_HIGH: begin
                        if (!s) begin
                            // Level dropped before persisting: reject as glitch.
                            state <= LOW;
                            cnt   <= '0;
                        end else if (take_rise) begin
                            state <= HIGH;
                            q     <= 1'b1;
                            rise  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    HIGH: begin
                        if (take_fall) begin
                            state <= LOW;
                            q     <= 1'b0;
                            fall  <= 1'b1;
                            cnt   <= '0;
                        end else if (!s) begin
                            state <= TO_LOW;
                            cnt   <= CW'(1);
                        end
                    end
                    TO_LOW: begin
                        if (s) begin
                            state <= HIGH;
                            cnt   <= '0;
                        end else if (take_fall) begin
                            state <= LOW;
                            q     <= 1'b0;
                            fall  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= LOW;
                        cnt   <= '0;
                        q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Transition counter: clear has priority, increments saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
        end else if (take_rise || take_fall) begin
            edge_cnt <= sat_inc(edge_cnt);
        end
    end

endmodule : debounce_edge_det

// File: tb/tb_debounce_edge_det.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge_det
//   Directed bench for debounce_edge_det: a per-cycle vector table for reset
//   release, glitch rejection and enable freeze, followed by hand-written
//   sequences for enable stall, toggle train with saturation, coincident
//   clear and asynchronous reset in the middle of a count.
// ---------------------------------------------------------------------------
module tb_debounce_edge_det;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d_async;
    logic       cnt_clr;

    logic       q;
    logic       rise;
    logic       fall;
    logic [7:0] edge_cnt;

    logic       q_s;
    logic       rise_s;
    logic       fall_s;
    logic [2:0] edge_cnt_s;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic en;
        logic d;
        logic clr;
        logic q;
        logic rise;
        logic fall;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    debounce_edge_det dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .d_async  (d_async),
        .cnt_clr  (cnt_clr),
        .q        (q),
        .rise     (rise),
        .fall     (fall),
        .edge_cnt (edge_cnt)
    );

    debounce_edge_det #(
        .CNT_W (3)
    ) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .d_async  (d_async),
        .cnt_clr  (cnt_clr),
        .q        (q_s),
        .rise     (rise_s),
        .fall     (fall_s),
        .edge_cnt (edge_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic dd, input logic c,
                       input logic eq, input logic er, input logic ef, input int ec);
        vec_t v;
        v.en = e; v.d = dd; v.clr = c;
        v.q = eq; v.rise = er; v.fall = ef; v.cnt = ec;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses;
        int pulse_at;
        int both_hi;
        int bad_cyc;
        int falls_seen;

        n_cmp = 0;
        n_bad = 0;

        // Rows: inputs applied before the edge, outputs expected after it.
        // Reset release with d high: rise at edge 6.
        for (int i = 1; i <= 5; i++) add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 1);
        add(1, 1, 0, 1, 0, 0, 1);
        // Full 1->0: fall six edges after d drops.
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        // Three-cycle glitch is rejected.
        for (int i = 1; i <= 3; i++) add(1, 1, 0, 0, 0, 0, 2);
        for (int i = 1; i <= 9; i++) add(1, 0, 0, 0, 0, 0, 2);
        // en=0 freezes the FSM even with a long high input.
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, 0, 0, 2);
        // Stale high left in the sync chain is seen for two cycles only.
        for (int i = 1; i <= 6; i++) add(1, 0, 0, 0, 0, 0, 2);

        rst_n   = 1'b0;
        en      = 1'b1;
        d_async = 1'b1;
        cnt_clr = 1'b0;
        repeat (3) step();
        chk("reset_q",    int'(q),        0);
        chk("reset_rise", int'(rise),     0);
        chk("reset_fall", int'(fall),     0);
        chk("reset_cnt",  int'(edge_cnt), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            en      = tbl[i].en;
            d_async = tbl[i].d;
            cnt_clr = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_q", i),    int'(q),        int'(tbl[i].q));
            chk($sformatf("vec%0d_rise", i), int'(rise),     int'(tbl[i].rise));
            chk($sformatf("vec%0d_fall", i), int'(fall),     int'(tbl[i].fall));
            chk($sformatf("vec%0d_cnt", i),  int'(edge_cnt), tbl[i].cnt);
        end

        // Enable stall: five disabled cycles mid-count push the rise from
        // edge 6 to edge 11.
        d_async  = 1'b1;
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= 12; i++) begin
            en = (i >= 5 && i <= 9) ? 1'b0 : 1'b1;
            step();
            if (rise) begin
                pulses++;
                pulse_at = i;
            end
            if (i == 10) chk("stall_q_before", int'(q), 0);
        end
        en = 1'b1;
        chk("stall_rise_count", pulses,        1);
        chk("stall_rise_edge",  pulse_at,      11);
        chk("stall_q",          int'(q),       1);
        chk("stall_cnt",        int'(edge_cnt), 3);

        // Clear both counters ahead of the toggle train.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_cnt",     int'(edge_cnt),   0);
        chk("clr_cnt_sat", int'(edge_cnt_s), 0);

        // Toggle train: 10-cycle half period, pulse at edge 6 of each half.
        both_hi = 0;
        for (int h = 0; h < 10; h++) begin
            d_async  = h[0];
            pulses   = 0;
            pulse_at = 0;
            for (int i = 1; i <= 10; i++) begin
                step();
                if (rise && fall) both_hi++;
                if (h[0] ? rise : fall) begin
                    pulses++;
                    pulse_at = i;
                end
                if (h[0] ? fall : rise) pulses += 100;
            end
            chk($sformatf("train%0d_pulses", h), pulses,   1);
            chk($sformatf("train%0d_edge", h),   pulse_at, 6);
            if (h == 7) chk("train_cnt8", int'(edge_cnt), 8);
        end
        chk("train_both_high", both_hi,           0);
        chk("train_cnt10",     int'(edge_cnt),    10);
        chk("train_sat",       int'(edge_cnt_s),  7);

        // Bring q low, then clear coincident with the next rise.
        d_async = 1'b0;
        repeat (10) step();
        chk("pre_clr_q", int'(q), 0);
        d_async = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cnt_clr = (i == 6) ? 1'b1 : 1'b0;
            step();
            if (i == 6) begin
                chk("coinc_rise", int'(rise),     1);
                chk("coinc_q",    int'(q),        1);
                chk("coinc_cnt",  int'(edge_cnt), 0);
            end
            if (i == 7) begin
                chk("coinc_rise_after", int'(rise),     0);
                chk("coinc_cnt_after",  int'(edge_cnt), 0);
            end
        end
        cnt_clr = 1'b0;

        // Asynchronous reset on the second cycle of a TO_LOW count.
        d_async = 1'b0;
        repeat (4) step();
        chk("mid_count_q", int'(q), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q",    int'(q),        0);
        chk("async_rst_fall", int'(fall),     0);
        chk("async_rst_cnt",  int'(edge_cnt), 0);
        repeat (2) step();
        rst_n      = 1'b1;
        falls_seen = 0;
        bad_cyc    = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (fall) falls_seen++;
            if (q || rise) bad_cyc++;
        end
        chk("post_rst_no_fall", falls_seen, 0);
        chk("post_rst_quiet",   bad_cyc,    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_debounce_edge_det
